// File: rtl/alu_regfile_datapath.sv
// rtl/alu_regfile_datapath.sv - 8-bit register file, operand-B select and ALU execution datapath
module alu_regfile_datapath #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITEENABLE,
  input  logic [AW-1:0]     WRITEREG,
  input  logic [AW-1:0]     READREG1,
  input  logic [AW-1:0]     READREG2,
  input  logic [DATA_W-1:0] IMMEDIATE,
  input  logic              COMPLEMENT_FLAG,
  input  logic              IMMEDIATE_FLAG,
  input  logic [2:0]        ALUOP,
  output logic [DATA_W-1:0] REGOUT1,
  output logic [DATA_W-1:0] REGOUT2,
  output logic [DATA_W-1:0] ALU_RESULT,
  output logic              ZERO
);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] result_d;

  // Reset overrides any write presented on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (WRITEENABLE) begin
      regs_q[WRITEREG] <= result_d;
    end
  end

  assign REGOUT1 = regs_q[READREG1];
  assign REGOUT2 = regs_q[READREG2];

  always_comb begin
    operand_b = REGOUT2;
    if (IMMEDIATE_FLAG) begin
      operand_b = IMMEDIATE;
    end else if (COMPLEMENT_FLAG) begin
      operand_b = ~REGOUT2 + {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    result_d = '0;
    case (ALUOP)
      OP_FWD:  result_d = operand_b;
      OP_ADD:  result_d = REGOUT1 + operand_b;
      OP_AND:  result_d = REGOUT1 & operand_b;
      OP_OR:   result_d = REGOUT1 | operand_b;
      default: result_d = '0;
    endcase
  end

  assign ALU_RESULT = result_d;
  assign ZERO       = (result_d == '0);

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// tb/tb_alu_regfile_datapath.sv - scoreboard bench for alu_regfile_datapath
module tb_alu_regfile_datapath;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       WRITEENABLE = 1'b0;
  logic [2:0] WRITEREG = '0, READREG1 = '0, READREG2 = '0, ALUOP = '0;
  logic [7:0] IMMEDIATE = '0;
  logic       COMPLEMENT_FLAG = 1'b0, IMMEDIATE_FLAG = 1'b0;
  logic [7:0] REGOUT1, REGOUT2, ALU_RESULT;
  logic       ZERO;

  alu_regfile_datapath dut (
    .CLK(CLK), .RESET(RESET), .WRITEENABLE(WRITEENABLE), .WRITEREG(WRITEREG),
    .READREG1(READREG1), .READREG2(READREG2), .IMMEDIATE(IMMEDIATE),
    .COMPLEMENT_FLAG(COMPLEMENT_FLAG), .IMMEDIATE_FLAG(IMMEDIATE_FLAG), .ALUOP(ALUOP),
    .REGOUT1(REGOUT1), .REGOUT2(REGOUT2), .ALU_RESULT(ALU_RESULT), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       id;
    bit [7:0] r1;
    bit [7:0] r2;
    bit [7:0] res;
    bit       z;
  } exp_t;

  exp_t     sb_q[$];
  int       checks = 0;
  int       failures = 0;
  int       step_id = 0;
  bit [7:0] mregs [8];

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  function automatic bit [7:0] model_alu(input int a, input int r2, input int imm,
                                         input bit cf, input bit imf, input int op);
    int b;
    if (imf)      b = imm;
    else if (cf)  b = (256 - r2) % 256;
    else          b = r2;
    case (op)
      0: return 8'(b);
      1: return 8'((a + b) % 256);
      2: return 8'(a & b);
      3: return 8'(a | b);
      default: return 8'h00;
    endcase
  endfunction

  // Called at posedge+1; drives one instruction, predicts its outputs, then models the edge.
  task automatic step(input bit rst, input bit we, input int wr, input int ra, input int rb,
                      input int imm, input bit cf, input bit imf, input int op);
    exp_t e;
    RESET = rst; WRITEENABLE = we; WRITEREG = 3'(wr); READREG1 = 3'(ra); READREG2 = 3'(rb);
    IMMEDIATE = 8'(imm); COMPLEMENT_FLAG = cf; IMMEDIATE_FLAG = imf; ALUOP = 3'(op);
    if (rst) foreach (mregs[i]) mregs[i] = 8'h00;
    e.id  = step_id++;
    e.r1  = mregs[ra];
    e.r2  = mregs[rb];
    e.res = model_alu(mregs[ra], mregs[rb], imm, cf, imf, op);
    e.z   = (e.res == 8'h00);
    sb_q.push_back(e);
    @(posedge CLK);
    if (we && !rst) mregs[wr] = e.res;
    #1;
  endtask

  task automatic loadi(input int wr, input int imm);
    step(0, 1, wr, 0, 0, imm, 0, 1, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("regout1", e.id, REGOUT1, e.r1);
        chk("regout2", e.id, REGOUT2, e.r2);
        chk("alu_result", e.id, ALU_RESULT, e.res);
        chk("zero", e.id, {7'b0, ZERO}, {7'b0, e.z});
      end
    end
  end

  initial begin : stim
    int budget;
    #2;
    chk("reset_regout1", -1, REGOUT1, 8'h00);
    chk("reset_zero", -1, {7'b0, ZERO}, 8'h01);
    foreach (mregs[i]) mregs[i] = 8'h00;
    @(posedge CLK); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) loadi(i, 8'hAA);
    step(0, 0, 0, 6, 7, 0, 0, 0, 3);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 2 * i, 2 * i + 1, 0, 0, 0, 1);
    loadi(1, 8'h05);
    loadi(2, 8'h03);
    step(0, 1, 3, 1, 2, 0, 0, 0, 1);
    step(0, 0, 0, 3, 2, 0, 1, 0, 1);
    step(0, 0, 0, 1, 2, 0, 1, 0, 1);
    step(0, 0, 0, 1, 2, 0, 0, 0, 2);
    step(0, 0, 0, 1, 2, 0, 0, 0, 3);
    step(0, 0, 0, 1, 1, 0, 1, 0, 1);
    loadi(4, 8'hFF);
    loadi(5, 8'h01);
    step(0, 0, 0, 4, 5, 0, 0, 0, 1);
    loadi(6, 8'h80);
    step(0, 0, 0, 0, 6, 0, 1, 0, 0);
    step(0, 0, 0, 1, 2, 8'h33, 1, 1, 0);
    step(0, 0, 0, 1, 2, 0, 0, 0, 5);
    step(0, 0, 1, 1, 2, 8'h77, 0, 1, 0);
    step(0, 1, 1, 1, 1, 8'h09, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 2, 1, 2, 8'h55, 0, 1, 0);
    step(0, 0, 0, 1, 2, 0, 0, 0, 1);
    step(0, 1, 2, 1, 2, 8'h5A, 0, 1, 0);
    step(0, 0, 0, 2, 1, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
           $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 7));
    end
    budget = 0;
    while (sb_q.size() > 0 && budget < 10) begin
      @(posedge CLK);
      budget++;
    end
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
